crc32_check: RTL and testbench

- Receive-side counterpart of the CRC-32 generator. It consumes a byte stream over a valid/ready handshake; the final 4 bytes of each frame are the transmitted CRC.
- Recomputes the CRC over the payload bit-serially, using the same poly, RefIn, Init and Xor_out semantics as the generator.
- Compares the result against the received CRC and reports match/mismatch with a one-cycle done pulse.
- Sits between the byte-receive path and the peripheral register block.

---
 rtl/crc32_pkg.sv | 24 ++
 rtl/bit_reverser.sv | 13 +
 rtl/crc32_bit_engine.sv | 79 +++++++
 rtl/crc32_check.sv | 246 ++++++++++++++++++++++++
 tb/tb_crc32_check.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc32_pkg.sv
// Shared definitions for the CRC-32 checker: FSM encoding, CRC constants,
// delay-buffer depth and a small mask helper.
package crc32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACCEPT     = 3'd1,
        ST_BYTE_XOR   = 3'd2,
        ST_POLY_SHIFT = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DONE       = 3'd5
    } crc_state_e;

    localparam logic [31:0] CRC32_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_STD = 32'h04C1_1DB7;
    localparam int          BUF_DEPTH      = 4;
    localparam logic [2:0]  BUF_FULL       = 3'(BUF_DEPTH);

    // All-ones when en is set, zero otherwise (Init value / final XOR mask).
    function automatic logic [31:0] crc32_mask(input logic en);
        return en ? CRC32_ALL_ONES : 32'h0000_0000;
    endfunction

endpackage

// File: rtl/bit_reverser.sv
// Purely combinational bit-order reversal: dout[i] = din[WIDTH-1-i].
module bit_reverser #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign dout[i] = din[WIDTH-1-i];
    end

endmodule

// File: rtl/crc32_bit_engine.sv
// Bit-serial CRC-32 datapath: byte fold-in, eight single-bit polynomial
// steps tracked by a 3-bit counter, and the reflected/normal polynomial mux.
module crc32_bit_engine
    import crc32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] init_val,
    input  logic        byte_xor,
    input  logic [7:0]  data_byte,
    input  logic        shift_en,
    input  logic        refin,
    input  logic [31:0] poly,
    output logic [31:0] crc,
    output logic        shift_last
);

    logic [31:0] poly_rev_s;
    logic [31:0] poly_eff_s;
    logic [31:0] crc_r;
    logic [31:0] crc_nxt_s;
    logic [2:0]  bit_cnt_r;

    bit_reverser #(.WIDTH(32)) u_poly_rev (
        .din  (poly),
        .dout (poly_rev_s)
    );

    // Reflected mode shifts right, so it needs the bit-reversed polynomial.
    always_comb begin
        if (refin) begin
            poly_eff_s = poly_rev_s;
        end else begin
            poly_eff_s = poly;
        end
    end

    // Next CRC value for load, byte fold-in and single-bit division step.
    always_comb begin
        crc_nxt_s = crc_r;
        if (load) begin
            crc_nxt_s = init_val;
        end else if (byte_xor) begin
            if (refin) begin
                crc_nxt_s = crc_r ^ {24'h00_0000, data_byte};
            end else begin
                crc_nxt_s = crc_r ^ {data_byte, 24'h00_0000};
            end
        end else if (shift_en) begin
            if (refin) begin
                crc_nxt_s = crc_r[0] ? ((crc_r >> 1) ^ poly_eff_s) : (crc_r >> 1);
            end else begin
                crc_nxt_s = crc_r[31] ? ((crc_r << 1) ^ poly_eff_s) : (crc_r << 1);
            end
        end else begin
            crc_nxt_s = crc_r;
        end
    end

    // CRC register and bit counter (counter wraps 7 -> 0 after each byte).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_r     <= 32'h0000_0000;
            bit_cnt_r <= 3'd0;
        end else begin
            crc_r <= crc_nxt_s;
            if (load) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    assign crc        = crc_r;
    assign shift_last = shift_en & (bit_cnt_r == 3'd7);

endmodule

// File: rtl/crc32_check.sv
// Receive-side CRC-32 checker. Bytes pass through a 4-deep delay buffer so
// the trailing 4 bytes (the transmitted CRC) never reach the CRC engine.
// Optional build macro CRC32_ERR_COUNT_EN adds err_clr / err_count[15:0].
module crc32_check
    import crc32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        RefIn,
    input  logic        Xor_out,
    input  logic        Init,
    input  logic [31:0] POLY_in,
    output logic        busy,
    output logic        done_pulse,
    output logic        crc_match,
    output logic        len_err,
    output logic [31:0] crc_calc,
    output logic [31:0] crc_rx
`ifdef CRC32_ERR_COUNT_EN
    ,
    input  logic        err_clr,
    output logic [15:0] err_count
`endif
);

    crc_state_e  state_r;
    crc_state_e  state_nxt_s;

    logic [7:0]  buf_r [0:BUF_DEPTH-1];
    logic [2:0]  count_r;
    logic [7:0]  pop_byte_r;
    logic        last_seen_r;

    logic        refin_r;
    logic        xorout_r;
    logic [31:0] poly_r;

    logic        in_ready_r;
    logic        busy_r;
    logic        done_pulse_r;
    logic        crc_match_r;
    logic        len_err_r;
    logic [31:0] crc_calc_r;
    logic [31:0] crc_rx_r;

    logic        hs_s;
    logic        first_s;
    logic        ready_nxt_s;
    logic        busy_nxt_s;
    logic        load_s;
    logic        xor_s;
    logic        shift_s;
    logic        check_s;
    logic        shift_last_s;
    logic [31:0] crc_s;
    logic [31:0] calc_s;
    logic [31:0] rx_s;
    logic        len_err_s;
    logic        match_s;

    // A handshake in IDLE or DONE starts a new frame.
    assign first_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign hs_s    = in_valid & in_ready_r;

    crc32_bit_engine u_engine (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .init_val   (crc32_mask(Init)),
        .byte_xor   (xor_s),
        .data_byte  (pop_byte_r),
        .shift_en   (shift_s),
        .refin      (refin_r),
        .poly       (poly_r),
        .crc        (crc_s),
        .shift_last (shift_last_s)
    );

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            done_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            in_ready_r   <= ready_nxt_s;
            busy_r       <= busy_nxt_s;
            done_pulse_r <= check_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (hs_s) begin
                    state_nxt_s = in_last ? ST_CHECK : ST_ACCEPT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (hs_s && (count_r == BUF_FULL)) begin
                    state_nxt_s = ST_BYTE_XOR;
                end else if (hs_s && in_last) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_ACCEPT;
                end
            end
            ST_BYTE_XOR: begin
                state_nxt_s = ST_POLY_SHIFT;
            end
            ST_POLY_SHIFT: begin
                if (shift_last_s) begin
                    state_nxt_s = last_seen_r ? ST_CHECK : ST_ACCEPT;
                end else begin
                    state_nxt_s = ST_POLY_SHIFT;
                end
            end
            ST_CHECK: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: registered ready/busy follow the next state; engine
    // strobes follow the current state.
    always_comb begin
        ready_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE:       begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
            ST_ACCEPT:     begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b1; end
            ST_BYTE_XOR:   begin ready_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
            ST_POLY_SHIFT: begin ready_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
            ST_CHECK:      begin ready_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
            ST_DONE:       begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
            default:       begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
        endcase
        load_s  = hs_s & first_s;
        xor_s   = (state_r == ST_BYTE_XOR);
        shift_s = (state_r == ST_POLY_SHIFT);
        check_s = (state_r == ST_CHECK);
    end

    // Result computation from the engine and the buffered trailer bytes.
    always_comb begin
        len_err_s = (count_r < BUF_FULL);
        calc_s    = crc_s ^ crc32_mask(xorout_r);
        if (refin_r) begin
            rx_s = {buf_r[3], buf_r[2], buf_r[1], buf_r[0]};
        end else begin
            rx_s = {buf_r[0], buf_r[1], buf_r[2], buf_r[3]};
        end
        match_s = (calc_s == rx_s) & ~len_err_s;
    end

    // Delay buffer, config latch and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_r[i] <= 8'h00;
            end
            count_r     <= 3'd0;
            pop_byte_r  <= 8'h00;
            last_seen_r <= 1'b0;
            refin_r     <= 1'b0;
            xorout_r    <= 1'b0;
            poly_r      <= 32'h0000_0000;
            crc_match_r <= 1'b0;
            len_err_r   <= 1'b0;
            crc_calc_r  <= 32'h0000_0000;
            crc_rx_r    <= 32'h0000_0000;
        end else begin
            if (hs_s) begin
                last_seen_r <= in_last;
                if (first_s) begin
                    buf_r[0]    <= in_data;
                    buf_r[1]    <= 8'h00;
                    buf_r[2]    <= 8'h00;
                    buf_r[3]    <= 8'h00;
                    count_r     <= 3'd1;
                    refin_r     <= RefIn;
                    xorout_r    <= Xor_out;
                    poly_r      <= POLY_in;
                    crc_match_r <= 1'b0;
                    len_err_r   <= 1'b0;
                    crc_calc_r  <= 32'h0000_0000;
                    crc_rx_r    <= 32'h0000_0000;
                end else if (count_r == BUF_FULL) begin
                    pop_byte_r <= buf_r[0];
                    buf_r[0]   <= buf_r[1];
                    buf_r[1]   <= buf_r[2];
                    buf_r[2]   <= buf_r[3];
                    buf_r[3]   <= in_data;
                end else begin
                    buf_r[count_r[1:0]] <= in_data;
                    count_r             <= count_r + 3'd1;
                end
            end
            if (check_s) begin
                crc_match_r <= match_s;
                len_err_r   <= len_err_s;
                crc_calc_r  <= calc_s;
                crc_rx_r    <= rx_s;
            end
        end
    end

`ifdef CRC32_ERR_COUNT_EN
    logic [15:0] err_count_r;

    // Saturating count of failed frames; err_clr takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_r <= 16'h0000;
        end else if (err_clr) begin
            err_count_r <= 16'h0000;
        end else if (check_s && !match_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end
    end

    assign err_count = err_count_r;
`endif

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign done_pulse = done_pulse_r;
    assign crc_match  = crc_match_r;
    assign len_err    = len_err_r;
    assign crc_calc   = crc_calc_r;
    assign crc_rx     = crc_rx_r;

endmodule

// File: tb/tb_crc32_check.sv
// Self-checking bench for crc32_check: directed vectors plus randomized
// frames compared against an MSB-first polynomial-division reference model.
module tb_crc32_check;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        RefIn;
    logic        Xor_out;
    logic        Init;
    logic [31:0] POLY_in;
    logic        busy;
    logic        done_pulse;
    logic        crc_match;
    logic        len_err;
    logic [31:0] crc_calc;
    logic [31:0] crc_rx;
`ifdef CRC32_ERR_COUNT_EN
    logic        err_clr;
    logic [15:0] err_count;
    int          err_exp;
`endif

    int          checks;
    int          errors;
    logic [7:0]  frame_q [$];

    localparam logic [31:0] POLY_STD = 32'h04C11DB7;

    crc32_check dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .RefIn      (RefIn),
        .Xor_out    (Xor_out),
        .Init       (Init),
        .POLY_in    (POLY_in),
        .busy       (busy),
        .done_pulse (done_pulse),
        .crc_match  (crc_match),
        .len_err    (len_err),
        .crc_calc   (crc_calc),
        .crc_rx     (crc_rx)
`ifdef CRC32_ERR_COUNT_EN
        ,
        .err_clr    (err_clr),
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Reference CRC over the first n bytes of frame_q. Reflected mode is
    // modelled as a normal CRC on bit-reversed bytes with a reversed result.
    function automatic logic [31:0] model_crc(input bit refin, input bit init, input bit xorout,
                                              input logic [31:0] poly, input int n);
        logic [31:0] c;
        logic [7:0]  d;
        c = init ? 32'hFFFFFFFF : 32'h00000000;
        for (int i = 0; i < n; i++) begin
            d = refin ? rev8(frame_q[i]) : frame_q[i];
            c = c ^ {d, 24'h000000};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
        end
        if (refin) c = rev32(c);
        if (xorout) c = ~c;
        return c;
    endfunction

    // Present one byte from a negedge and wait (bounded) for its handshake.
    task automatic send_byte(input logic [7:0] b, input bit last, output int waits);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        waits    = 0;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) check("handshake_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Send frame_q as one frame and compare all results with the model.
    task automatic run_frame(input string tag, input bit refin, input bit init, input bit xorout,
                             input logic [31:0] poly, input bit chk_tp,
                             output logic [31:0] got_calc, output logic got_match);
        int          size, n, w, dcnt;
        logic [31:0] e_calc, e_rx, c_calc, c_rx;
        logic        e_len, e_match, c_match, c_len;
        size    = frame_q.size();
        n       = (size > 4) ? size - 4 : 0;
        e_len   = (size < 4);
        e_calc  = model_crc(refin, init, xorout, poly, n);
        e_rx    = 32'h0;
        if (!e_len) begin
            if (refin) e_rx = {frame_q[n+3], frame_q[n+2], frame_q[n+1], frame_q[n]};
            else       e_rx = {frame_q[n], frame_q[n+1], frame_q[n+2], frame_q[n+3]};
        end
        e_match = !e_len && (e_calc == e_rx);
        RefIn   = refin;
        Init    = init;
        Xor_out = xorout;
        POLY_in = poly;
        for (int i = 0; i < size; i++) begin
            send_byte(frame_q[i], i == size - 1, w);
            if (i == 0) begin
                #1;
                check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
                RefIn   = 1'($urandom);
                Init    = 1'($urandom);
                Xor_out = 1'($urandom);
                POLY_in = $urandom;
            end
            if (chk_tp && i > 0) check($sformatf("%s_wait%0d", tag, i), 32'(w), (i >= 5) ? 32'd9 : 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        dcnt = 0;
        c_calc = 32'h0; c_rx = 32'h0; c_match = 1'b0; c_len = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_pulse) begin
                dcnt++;
                c_calc = crc_calc; c_rx = crc_rx; c_match = crc_match; c_len = len_err;
            end
            @(negedge clk);
        end
        check($sformatf("%s_done_cnt", tag), 32'(dcnt), 32'd1);
        check($sformatf("%s_len_err", tag), 32'(c_len), 32'(e_len));
        check($sformatf("%s_match", tag), 32'(c_match), 32'(e_match));
        check($sformatf("%s_calc", tag), c_calc, e_calc);
        if (!e_len) check($sformatf("%s_rx", tag), c_rx, e_rx);
        check($sformatf("%s_hold", tag), 32'(crc_match), 32'(e_match));
        check($sformatf("%s_idle_busy", tag), 32'(busy), 32'd0);
`ifdef CRC32_ERR_COUNT_EN
        if (err_clr) err_exp = 0;
        else if (!e_match && err_exp < 65535) err_exp++;
`endif
        got_calc  = c_calc;
        got_match = c_match;
    endtask

    task automatic load_tv(input logic [7:0] t0, input logic [7:0] t1,
                           input logic [7:0] t2, input logic [7:0] t3);
        frame_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, t0, t1, t2, t3};
    endtask

    initial begin
        logic [31:0] gc, crc;
        logic        gm;
        int          w, dcnt, len, n;
        bit          rf, it, xo, good;
        logic [31:0] pl;

        checks = 0; errors = 0;
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        RefIn = 1'b0; Xor_out = 1'b0; Init = 1'b0; POLY_in = 32'h0;
`ifdef CRC32_ERR_COUNT_EN
        err_clr = 1'b0; err_exp = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_match", 32'(crc_match), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_calc", crc_calc, 32'h0);
        check("rst_rx", crc_rx, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reflected CRC-32 check value, with throughput measurement.
        load_tv(8'h26, 8'h39, 8'hF4, 8'hCB);
        run_frame("tv_refl", 1'b1, 1'b1, 1'b1, POLY_STD, 1'b1, gc, gm);
        check("tv_refl_const", gc, 32'hCBF43926);
        check("tv_refl_const_m", 32'(gm), 32'd1);

        // One payload byte corrupted.
        load_tv(8'h26, 8'h39, 8'hF4, 8'hCB);
        frame_q[4] = 8'h36;
        run_frame("tv_bad", 1'b1, 1'b1, 1'b1, POLY_STD, 1'b0, gc, gm);
        check("tv_bad_m", 32'(gm), 32'd0);

        // Non-reflected, no final XOR.
        load_tv(8'h03, 8'h76, 8'hE6, 8'hE7);
        run_frame("tv_norm", 1'b0, 1'b1, 1'b0, POLY_STD, 1'b0, gc, gm);
        check("tv_norm_const", gc, 32'h0376E6E7);

        // Non-reflected with final XOR.
        load_tv(8'hFC, 8'h89, 8'h19, 8'h18);
        run_frame("tv_nx", 1'b0, 1'b1, 1'b1, POLY_STD, 1'b0, gc, gm);
        check("tv_nx_const", gc, 32'hFC891918);

        // Short frames and the empty-payload case.
        frame_q = {8'hA5, 8'h5A};
        run_frame("short2", 1'b1, 1'b1, 1'b1, POLY_STD, 1'b0, gc, gm);
        frame_q = {8'h11};
        run_frame("short1", 1'b0, 1'b0, 1'b1, POLY_STD, 1'b0, gc, gm);
        frame_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame("empty4", 1'b0, 1'b1, 1'b0, POLY_STD, 1'b0, gc, gm);

        // Reset while the engine is shifting.
        load_tv(8'h26, 8'h39, 8'hF4, 8'hCB);
        RefIn = 1'b1; Init = 1'b1; Xor_out = 1'b1; POLY_in = POLY_STD;
        for (int i = 0; i < 5; i++) send_byte(frame_q[i], 1'b0, w);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done_pulse), 32'd0);
        check("mid_rst_match", 32'(crc_match), 32'd0);
        check("mid_rst_calc", crc_calc, 32'h0);
        check("mid_rst_rx", crc_rx, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_pulse) dcnt++;
        end
        check("mid_rst_no_done", 32'(dcnt), 32'd0);
`ifdef CRC32_ERR_COUNT_EN
        err_exp = 0;
        check("errcnt_after_rst", 32'(err_count), 32'd0);
`endif
        load_tv(8'h26, 8'h39, 8'hF4, 8'hCB);
        run_frame("post_rst", 1'b1, 1'b1, 1'b1, POLY_STD, 1'b0, gc, gm);
        check("post_rst_m", 32'(gm), 32'd1);

`ifdef CRC32_ERR_COUNT_EN
        for (int f = 0; f < 3; f++) begin
            load_tv(8'h26, 8'h39, 8'hF4, 8'hCA);
            run_frame($sformatf("ec_bad%0d", f), 1'b1, 1'b1, 1'b1, POLY_STD, 1'b0, gc, gm);
        end
        check("errcnt_3", 32'(err_count), 32'd3);
        err_clr = 1'b1;
        load_tv(8'h26, 8'h39, 8'hF4, 8'hCA);
        run_frame("ec_clr", 1'b1, 1'b1, 1'b1, POLY_STD, 1'b0, gc, gm);
        err_clr = 1'b0;
        check("errcnt_clr", 32'(err_count), 32'd0);
`endif

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            len  = $urandom_range(1, 12);
            rf   = 1'($urandom); it = 1'($urandom); xo = 1'($urandom);
            pl   = ($urandom_range(0, 1) == 0) ? POLY_STD : ($urandom | 32'h1);
            good = 1'($urandom);
            frame_q = {};
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            if (len >= 4 && good) begin
                n   = len - 4;
                crc = model_crc(rf, it, xo, pl, n);
                for (int k = 0; k < 4; k++) begin
                    frame_q[n+k] = rf ? crc[8*k +: 8] : crc[8*(3-k) +: 8];
                end
            end
            run_frame($sformatf("rnd%0d", f), rf, it, xo, pl, 1'b0, gc, gm);
        end
`ifdef CRC32_ERR_COUNT_EN
        check("errcnt_final", 32'(err_count), 32'(err_exp));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
